// File: rtl/fir_ctrl_pkg.sv
// Shared definitions for filter-chain controllers: sequencer state encoding,
// offset-binary midscale constant and a width helper.
package fir_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } fir_state_t;

    // Bits needed to index 'value' entries (ceil(log2(value))).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    // Offset-binary zero for a 'width'-bit sample; callers truncate to width.
    function automatic logic [63:0] midscale(input int width);
        return 64'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/fir_sample_fifo.sv
// Synchronous sample FIFO with occupancy count and flush; a push into a full
// FIFO succeeds only when a pop happens on the same edge.
module fir_sample_fifo
    import fir_ctrl_pkg::*;
#(
    parameter int BITSIZE    = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic                        push,
    input  logic                        pop,
    input  logic [BITSIZE-1:0]          din,
    output logic [BITSIZE-1:0]          head,
    output logic                        full,
    output logic                        empty,
    output logic [clog2(FIFO_DEPTH):0]  level
);

    localparam int AW = clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_LEVEL = FIFO_DEPTH[AW:0];

    logic [BITSIZE-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic               do_push;
    logic               do_pop;

    assign full    = (level == FULL_LEVEL);
    assign empty   = (level == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // NOTE: the storage array is deliberately not reset; pointers and level
    // alone decide which entries are valid, so it can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      level <= level + 1'b1;
            else if (do_pop && !do_push) level <= level - 1'b1;
        end
    end

endmodule

// File: rtl/fir_sample_scheduler.sv
// Sequencer between a bursty ADC stream and one FIR instance: buffers samples,
// starts the filter only when idle, waits for its result with a timeout.
module fir_sample_scheduler
    import fir_ctrl_pkg::*;
#(
    parameter int BITSIZE     = 16,
    parameter int FIFO_DEPTH  = 4,
    parameter int START_WIDTH = 2,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic                        clr_flags,
    input  logic                        adc_valid,
    input  logic [BITSIZE-1:0]          adc_data,
    output logic                        fir_en,
    output logic                        fir_start,
    output logic [BITSIZE-1:0]          fir_din,
    input  logic [BITSIZE-1:0]          fir_dout,
    input  logic                        fir_valid,
    output logic [BITSIZE-1:0]          data_out,
    output logic                        data_valid,
    output logic [clog2(FIFO_DEPTH):0]  fill_level,
    output logic                        overflow,
    output logic                        timeout
);

    localparam logic [BITSIZE-1:0] MIDSCALE = BITSIZE'(midscale(BITSIZE));
    localparam int CW = clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] START_LAST   = CW'(START_WIDTH - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYC - 1);

    fir_state_t         state;
    logic [CW-1:0]      cnt;
    logic               fir_valid_q;
    logic               push_req;
    logic               pop_req;
    logic               fifo_full;
    logic               fifo_empty;
    logic [BITSIZE-1:0] head;
    logic               fir_rise;
    logic               drop;
    logic               timeout_set;

    assign push_req    = en && adc_valid;
    assign pop_req     = en && fir_en && (state == ST_IDLE);
    assign fir_rise    = fir_valid && !fir_valid_q;
    // A full FIFO is never empty, so a pop on this edge always frees a slot.
    assign drop        = push_req && fifo_full && !pop_req;
    assign timeout_set = en && (state == ST_WAIT) && !fir_rise && (cnt == TIMEOUT_LAST);

    fir_sample_fifo #(
        .BITSIZE    (BITSIZE),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (!en),
        .push  (push_req),
        .pop   (pop_req),
        .din   (adc_data),
        .head  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fill_level)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            fir_en      <= 1'b0;
            fir_start   <= 1'b0;
            fir_din     <= MIDSCALE;
            data_out    <= MIDSCALE;
            data_valid  <= 1'b0;
            overflow    <= 1'b0;
            timeout     <= 1'b0;
            fir_valid_q <= 1'b0;
        end else begin
            fir_en      <= en;
            fir_valid_q <= fir_valid;
            data_valid  <= 1'b0;
            // Set events win over a simultaneous clear.
            overflow    <= drop || (overflow && !clr_flags);
            timeout     <= timeout_set || (timeout && !clr_flags);

            if (!en) begin
                state     <= ST_IDLE;
                fir_start <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (fir_en && !fifo_empty) begin
                            fir_din   <= head;
                            fir_start <= 1'b1;
                            cnt       <= '0;
                            state     <= ST_START;
                        end
                    end
                    ST_START: begin
                        cnt <= cnt + 1'b1;
                        if (cnt == START_LAST) begin
                            fir_start <= 1'b0;
                            state     <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        cnt <= cnt + 1'b1;
                        if (fir_rise) begin
                            data_out   <= fir_dout;
                            data_valid <= 1'b1;
                            state      <= ST_IDLE;
                        end else if (cnt == TIMEOUT_LAST) begin
                            state <= ST_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
